// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage feeding the decoder. Holds a 32-entry
//               program memory (loaded through a program port while idle or
//               halted), a fetch program counter, and a registered instruction
//               output. Sequences start (IDLE -> FILL -> RUN) and halt.
//               Optional macro FETCH_PERF_EN builds a saturating counter of
//               instructions loaded from memory; without it perf_cnt is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int             DW       = 32,
    parameter int             AW       = 5,
    parameter int             DEPTH    = 32,
    parameter logic [7:0]     HALT_OP  = 8'hFF,
    parameter logic [DW-1:0]  NOP_INST = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic           prog_we,
    input  logic [AW-1:0]  prog_addr,
    input  logic [DW-1:0]  prog_data,
    input  logic           dec_rst,
    input  logic           dec_pc_inc,
    input  logic           dec_jmp,
    input  logic [AW-1:0]  dec_jmp_add,
    output logic [DW-1:0]  inst,
    output logic [AW-1:0]  inst_pc,
    output logic           valid,
    output logic           halted,
    output logic [15:0]    perf_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    // AW-bit increment: wraps 31 -> 0 because DEPTH == 2**AW
    localparam logic [AW-1:0] c_addr_one = AW'(1);

    state_t          r_state;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [DW-1:0]   r_inst;
    logic [AW-1:0]   r_inst_pc;
    logic [AW-1:0]   r_fetch_pc;
    logic            r_valid;
    logic            r_halted;

    logic            w_prog_open;
    logic            w_is_halt;

    // The program port is only open while nothing is being fetched
    assign w_prog_open = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_is_halt   = (r_inst[DW-1:DW-8] == HALT_OP);

    // Program memory write port; contents survive reset on purpose
    always_ff @(posedge clk) begin
        if (rst_n && prog_we && w_prog_open) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // Fetch sequencer: synchronous memory read captured straight into r_inst
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_inst     <= NOP_INST;
            r_inst_pc  <= '0;
            r_fetch_pc <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_inst     <= r_mem[r_fetch_pc];
                    r_inst_pc  <= r_fetch_pc;
                    r_fetch_pc <= r_fetch_pc + c_addr_one;
                    r_valid    <= 1'b1;
                    r_state    <= S_RUN;
                end
                S_RUN: begin
                    // A halt opcode on the output wins over any decoder request
                    if (w_is_halt) begin
                        r_state  <= S_HALT;
                        r_valid  <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (dec_rst) begin
                        r_fetch_pc <= '0;
                        r_inst     <= NOP_INST;
                        r_inst_pc  <= '0;
                        r_valid    <= 1'b0;
                        r_state    <= S_FILL;
                    end else if (dec_jmp) begin
                        r_inst     <= r_mem[dec_jmp_add];
                        r_inst_pc  <= dec_jmp_add;
                        r_fetch_pc <= dec_jmp_add + c_addr_one;
                    end else if (dec_pc_inc) begin
                        r_inst     <= r_mem[r_fetch_pc];
                        r_inst_pc  <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + c_addr_one;
                    end
                end
                S_HALT: begin
                    // Restart always begins again from address 0
                    if (run) begin
                        r_fetch_pc <= '0;
                        r_halted   <= 1'b0;
                        r_state    <= S_FILL;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_cnt;
    logic        w_load;

    // An instruction is loaded on FILL and on every jump/advance in RUN
    always_comb begin
        w_load = 1'b0;
        if (r_state == S_FILL) begin
            w_load = 1'b1;
        end else if ((r_state == S_RUN) && !w_is_halt && !dec_rst
                     && (dec_jmp || dec_pc_inc)) begin
            w_load = 1'b1;
        end
    end

    // Saturating load counter; only the hard reset clears it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_cnt <= '0;
        end else if (w_load && (r_perf_cnt != 16'hFFFF)) begin
            r_perf_cnt <= r_perf_cnt + 16'd1;
        end
    end

    assign perf_cnt = r_perf_cnt;
`else
    assign perf_cnt = '0;
`endif

    assign inst    = r_inst;
    assign inst_pc = r_inst_pc;
    assign valid   = r_valid;
    assign halted  = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A directed vector table
//               walks the load/halt/jump/wrap/stall/soft-reset/hard-reset
//               scenarios, then random traffic is checked against a
//               behavioural model of the fetch rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

`ifdef FETCH_PERF_EN
    localparam bit c_perf_en = 1'b1;
`else
    localparam bit c_perf_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        dec_rst = 1'b0;
    logic        dec_pc_inc = 1'b0;
    logic        dec_jmp = 1'b0;
    logic [4:0]  dec_jmp_add = '0;
    logic [31:0] inst;
    logic [4:0]  inst_pc;
    logic        valid;
    logic        halted;
    logic [15:0] perf_cnt;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .dec_rst     (dec_rst),
        .dec_pc_inc  (dec_pc_inc),
        .dec_jmp     (dec_jmp),
        .dec_jmp_add (dec_jmp_add),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .valid       (valid),
        .halted      (halted),
        .perf_cnt    (perf_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE = 0, M_FILL = 1, M_RUN = 2, M_HALT = 3;
    logic [31:0] m_mem [32];
    int          m_mode;
    logic [31:0] m_inst;
    int          m_pc;
    int          m_fpc;
    logic        m_valid;
    logic        m_halted;
    int          m_perf;

    task automatic m_load(input int a);
        m_inst = m_mem[a];
        m_pc   = a;
        m_fpc  = (a + 1) % 32;
        if (m_perf < 65535) m_perf = m_perf + 1;
    endtask

    // Advance the model by one clock edge using the inputs now being driven
    task automatic model_step();
        if (!rst_n) begin
            m_mode = M_IDLE; m_inst = 32'h0; m_pc = 0; m_fpc = 0;
            m_valid = 1'b0; m_halted = 1'b0; m_perf = 0;
        end else if (m_mode == M_IDLE || m_mode == M_HALT) begin
            if (prog_we) m_mem[prog_addr] = prog_data;
            if (run) begin
                m_fpc = (m_mode == M_HALT) ? 0 : m_fpc;
                m_halted = 1'b0;
                m_mode = M_FILL;
            end
        end else if (m_mode == M_FILL) begin
            m_load(m_fpc);
            m_valid = 1'b1;
            m_mode = M_RUN;
        end else begin
            if (m_inst[31:24] == 8'hFF) begin
                m_mode = M_HALT; m_valid = 1'b0; m_halted = 1'b1;
            end else if (dec_rst) begin
                m_fpc = 0; m_inst = 32'h0; m_pc = 0; m_valid = 1'b0;
                m_mode = M_FILL;
            end else if (dec_jmp) begin
                m_load(int'(dec_jmp_add));
            end else if (dec_pc_inc) begin
                m_load(m_fpc);
            end
        end
    endtask

    // ---------------- stimulus / check helpers ----------------
    task automatic drive(input logic r, input logic rn, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic dr, input logic inc, input logic jp,
                         input logic [4:0] ja);
        rst_n = r; run = rn; prog_we = we; prog_addr = wa; prog_data = wd;
        dec_rst = dr; dec_pc_inc = inc; dec_jmp = jp; dec_jmp_add = ja;
    endtask

    task automatic check(input string tag, input logic [31:0] ei,
                         input logic [4:0] ep, input logic ev,
                         input logic eh, input logic [15:0] ef);
        logic [15:0] ef_eff;
        ef_eff = c_perf_en ? ef : 16'h0;
        n_vec++;
        if (inst !== ei || inst_pc !== ep || valid !== ev || halted !== eh
            || perf_cnt !== ef_eff) begin
            n_miss++;
            $display("FAIL %s: got inst=%h pc=%0d valid=%b halted=%b perf=%0d, want inst=%h pc=%0d valid=%b halted=%b perf=%0d",
                     tag, inst, inst_pc, valid, halted, perf_cnt,
                     ei, ep, ev, eh, ef_eff);
        end
    endtask

    // Clock one edge, then sample mid-cycle
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check(tag, m_inst, 5'(m_pc), m_valid, m_halted, 16'(m_perf));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r, rn, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        dr, inc, jp;
        logic [4:0]  ja;
        logic [31:0] ei;
        logic [4:0]  ep;
        logic        ev, eh;
        logic [15:0] ef;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic rn, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic dr, input logic inc, input logic jp,
                       input logic [4:0] ja, input logic [31:0] ei,
                       input logic [4:0] ep, input logic ev, input logic eh,
                       input logic [15:0] ef);
        vec_t v;
        v.r = r; v.rn = rn; v.we = we; v.wa = wa; v.wd = wd;
        v.dr = dr; v.inc = inc; v.jp = jp; v.ja = ja;
        v.ei = ei; v.ep = ep; v.ev = ev; v.eh = eh; v.ef = ef;
        tbl.push_back(v);
    endtask

    initial begin
        //   r rn we wa  wd            dr in jp ja   inst          pc v  h  perf
        // reset and load program in IDLE
        add(0, 0, 0, 0,  32'h0,        0, 0, 0, 0,  32'h00000000, 0, 0, 0, 0);
        add(1, 0, 1, 0,  32'h07050a01, 0, 0, 0, 0,  32'h00000000, 0, 0, 0, 0);
        add(1, 0, 1, 1,  32'h01000201, 0, 0, 0, 0,  32'h00000000, 0, 0, 0, 0);
        add(1, 0, 1, 2,  32'hFF000000, 0, 0, 0, 0,  32'h00000000, 0, 0, 0, 0);
        // run, fill, advance to the halt opcode
        add(1, 1, 0, 0,  32'h0,        0, 1, 0, 0,  32'h00000000, 0, 0, 0, 0);
        add(1, 0, 0, 0,  32'h0,        0, 1, 0, 0,  32'h07050a01, 0, 1, 0, 1);
        add(1, 0, 0, 0,  32'h0,        0, 1, 0, 0,  32'h01000201, 1, 1, 0, 2);
        add(1, 0, 0, 0,  32'h0,        0, 1, 0, 0,  32'hFF000000, 2, 1, 0, 3);
        add(1, 0, 0, 0,  32'h0,        0, 1, 1, 9,  32'hFF000000, 2, 0, 1, 3);
        // writes while halted are accepted
        add(1, 0, 1, 2,  32'h02020202, 0, 0, 0, 0,  32'hFF000000, 2, 0, 1, 3);
        add(1, 0, 1, 20, 32'h08000900, 0, 0, 0, 0,  32'hFF000000, 2, 0, 1, 3);
        add(1, 0, 1, 21, 32'h15151515, 0, 0, 0, 0,  32'hFF000000, 2, 0, 1, 3);
        add(1, 0, 1, 31, 32'h31313131, 0, 0, 0, 0,  32'hFF000000, 2, 0, 1, 3);
        add(1, 0, 1, 7,  32'h07070707, 0, 0, 0, 0,  32'hFF000000, 2, 0, 1, 3);
        // write + run in the same cycle: the fill sees the new mem[0]
        add(1, 1, 1, 0,  32'h0A0A0A0A, 0, 0, 0, 0,  32'hFF000000, 2, 0, 0, 3);
        add(1, 0, 0, 0,  32'h0,        0, 0, 0, 0,  32'h0A0A0A0A, 0, 1, 0, 4);
        add(1, 0, 0, 0,  32'h0,        0, 1, 0, 0,  32'h01000201, 1, 1, 0, 5);
        // jump from pc 1 to 20, then advance
        add(1, 0, 0, 0,  32'h0,        0, 0, 1, 20, 32'h08000900, 20, 1, 0, 6);
        add(1, 0, 0, 0,  32'h0,        0, 1, 0, 0,  32'h15151515, 21, 1, 0, 7);
        // four stall cycles
        add(1, 0, 0, 0,  32'h0,        0, 0, 0, 0,  32'h15151515, 21, 1, 0, 7);
        add(1, 0, 0, 0,  32'h0,        0, 0, 0, 0,  32'h15151515, 21, 1, 0, 7);
        add(1, 0, 0, 0,  32'h0,        0, 0, 0, 0,  32'h15151515, 21, 1, 0, 7);
        add(1, 0, 0, 0,  32'h0,        0, 0, 0, 0,  32'h15151515, 21, 1, 0, 7);
        // jump to 31 then advance wraps to 0
        add(1, 0, 0, 0,  32'h0,        0, 0, 1, 31, 32'h31313131, 31, 1, 0, 8);
        add(1, 0, 0, 0,  32'h0,        0, 1, 0, 0,  32'h0A0A0A0A, 0, 1, 0, 9);
        // program write during RUN must be ignored
        add(1, 0, 1, 1,  32'hDEADBEEF, 0, 0, 0, 0,  32'h0A0A0A0A, 0, 1, 0, 9);
        // soft reset beats a simultaneous jump
        add(1, 0, 0, 0,  32'h0,        0, 0, 1, 7,  32'h07070707, 7, 1, 0, 10);
        add(1, 0, 0, 0,  32'h0,        1, 1, 1, 20, 32'h00000000, 0, 0, 0, 10);
        add(1, 0, 0, 0,  32'h0,        0, 0, 0, 0,  32'h0A0A0A0A, 0, 1, 0, 11);
        add(1, 0, 0, 0,  32'h0,        0, 1, 0, 0,  32'h01000201, 1, 1, 0, 12);
        // hard reset mid-RUN (write during reset ignored), then restart
        add(0, 0, 1, 0,  32'hBADBAD00, 0, 1, 0, 0,  32'h00000000, 0, 0, 0, 0);
        add(1, 1, 0, 0,  32'h0,        0, 0, 0, 0,  32'h00000000, 0, 0, 0, 0);
        add(1, 0, 0, 0,  32'h0,        0, 0, 0, 0,  32'h0A0A0A0A, 0, 1, 0, 1);
    end

    // ---------------- main sequence ----------------
    initial begin
        #1;
        // Preload every entry so no read ever returns uninitialised data
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_model("init_reset");
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 1, 5'(i), 32'h01010101 * i, 0, 0, 0, 0);
            tick();
            check_model($sformatf("init_wr%0d", i));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].rn, tbl[i].we, tbl[i].wa, tbl[i].wd,
                  tbl[i].dr, tbl[i].inc, tbl[i].jp, tbl[i].ja);
            tick();
            check($sformatf("tbl%0d", i), tbl[i].ei, tbl[i].ep, tbl[i].ev,
                  tbl[i].eh, tbl[i].ef);
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] wd;
            wd = $urandom;
            if ($urandom_range(15) == 0) wd[31:24] = 8'hFF;
            else if (wd[31:24] == 8'hFF) wd[31:24] = 8'h00;
            drive(($urandom_range(63) != 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(3) == 0),
                  5'($urandom_range(31)),
                  wd,
                  ($urandom_range(19) == 0),
                  ($urandom_range(1) == 0),
                  ($urandom_range(5) == 0),
                  5'($urandom_range(31)));
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
